// File: rtl/masked_pkg.sv
// Purpose: shared types for the masked (two-share Boolean) carry stages.
// Latency: none, declarations only.
// Backpressure: not applicable.
package masked_pkg;

    localparam int unsigned N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_A = 2'd1,
        RUN_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One first-order Boolean-shared bit: value = s0 ^ s1.
    typedef struct packed {
        logic s0;
        logic s1;
    } share_t;

endpackage

// File: rtl/masked_dom_and.sv
// Purpose: one-bit domain-oriented masked AND, inner and cross terms registered separately.
// Latency: 1 cycle from i_en to o_inner/o_cross; the caller does the final XOR.
// Backpressure: none; registers hold their value while i_en is low.
module masked_dom_and
    import masked_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_en,
    input  share_t i_a,
    input  share_t i_b,
    input  logic   i_r,
    output share_t o_inner,
    output share_t o_cross
);

    share_t r_inner;
    share_t r_cross;

    // Capture same-domain products and refreshed cross-domain products; the
    // cross terms are the only place the two domains meet, and they are
    // masked by i_r and registered before anyone recombines them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inner <= '0;
            r_cross <= '0;
        end else if (i_en) begin
            r_inner.s0 <= i_a.s0 & i_b.s0;
            r_inner.s1 <= i_a.s1 & i_b.s1;
            r_cross.s0 <= (i_a.s0 & i_b.s1) ^ i_r;
            r_cross.s1 <= (i_a.s1 & i_b.s0) ^ i_r;
        end
    end

    assign o_inner = r_inner;
    assign o_cross = r_cross;

endmodule

// File: rtl/masked_carry_serial.sv
// Purpose: bit-serial masked carry resolver producing shared sum and carry-out from shared p/g.
// Latency: accept at T, o_valid first high at T+2N+1; one job per 2N+2 cycles at best.
// Backpressure: result held in DONE while i_ready is low; o_ready only high in IDLE.
module masked_carry_serial
    import masked_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_p0,
    input  logic [N-1:0] i_p1,
    input  logic [N-1:0] i_g0,
    input  logic [N-1:0] i_g1,
    input  logic         i_ci0,
    input  logic         i_ci1,
    input  logic         i_rN,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_s0,
    output logic [N-1:0] o_s1,
    output logic         o_co0,
    output logic         o_co1
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_k;
    logic [N-1:0]  r_p0, r_p1, r_g0, r_g1;
    logic [N-1:0]  r_s0, r_s1;
    logic          r_c0, r_c1;

    logic          w_accept;
    logic          w_phase_a;
    logic          w_phase_b;
    logic          w_last;
    share_t        w_a;
    share_t        w_b;
    share_t        w_inner;
    share_t        w_cross;

    assign w_last = (r_k == CW'(N - 1));

    // Current bit's propagate shares against the running carry shares.
    assign w_a.s0 = r_p0[r_k];
    assign w_a.s1 = r_p1[r_k];
    assign w_b.s0 = r_c0;
    assign w_b.s1 = r_c1;

    // p[k] & c[k] is evaluated in phase A; its terms are ready in phase B.
    masked_dom_and u_dom_and (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_phase_a),
        .i_a     (w_a),
        .i_b     (w_b),
        .i_r     (i_rN),
        .o_inner (w_inner),
        .o_cross (w_cross)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake outputs and per-phase enables.
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        w_accept    = 1'b0;
        w_phase_a   = 1'b0;
        w_phase_b   = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN_A;
                end
            end
            RUN_A: begin
                w_phase_a   = 1'b1;
                w_state_nxt = RUN_B;
            end
            RUN_B: begin
                w_phase_b   = 1'b1;
                w_state_nxt = w_last ? DONE : RUN_A;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Job datapath: latch operands, emit sum bits in phase A, advance the
    // carry shares in phase B. Each carry share only mixes its own domain
    // with its registered cross term.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k  <= '0;
            r_p0 <= '0;
            r_p1 <= '0;
            r_g0 <= '0;
            r_g1 <= '0;
            r_s0 <= '0;
            r_s1 <= '0;
            r_c0 <= 1'b0;
            r_c1 <= 1'b0;
        end else begin
            if (w_accept) begin
                r_p0 <= i_p0;
                r_p1 <= i_p1;
                r_g0 <= i_g0;
                r_g1 <= i_g1;
                r_c0 <= i_ci0;
                r_c1 <= i_ci1;
                r_k  <= '0;
            end
            if (w_phase_a) begin
                r_s0[r_k] <= r_p0[r_k] ^ r_c0;
                r_s1[r_k] <= r_p1[r_k] ^ r_c1;
            end
            if (w_phase_b) begin
                r_c0 <= r_g0[r_k] ^ w_inner.s0 ^ w_cross.s0;
                r_c1 <= r_g1[r_k] ^ w_inner.s1 ^ w_cross.s1;
                if (!w_last) begin
                    r_k <= r_k + CW'(1);
                end
            end
        end
    end

    assign o_s0  = r_s0;
    assign o_s1  = r_s1;
    assign o_co0 = r_c0;
    assign o_co1 = r_c1;

endmodule

// File: tb/tb_masked_carry_serial.sv
// Purpose: directed self-checking bench for masked_carry_serial (N = 8).
// Latency: checks first o_valid exactly 2N edges after the accept edge.
// Backpressure: exercises i_ready stalls, busy-time i_valid and mid-job reset.
module tb_masked_carry_serial;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         trst;
    logic         tvalid;
    logic         o_ready;
    logic [N-1:0] tp0, tp1, tg0, tg1;
    logic         tci0, tci1;
    logic         trn;
    logic         o_valid;
    logic         tready;
    logic [N-1:0] o_s0, o_s1;
    logic         o_co0, o_co1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    masked_carry_serial #(.N(N)) dut (
        .i_clk   (clk),
        .i_rst   (trst),
        .i_valid (tvalid),
        .o_ready (o_ready),
        .i_p0    (tp0),
        .i_p1    (tp1),
        .i_g0    (tg0),
        .i_g1    (tg1),
        .i_ci0   (tci0),
        .i_ci1   (tci1),
        .i_rN    (trn),
        .o_valid (o_valid),
        .i_ready (tready),
        .o_s0    (o_s0),
        .o_s1    (o_s1),
        .o_co0   (o_co0),
        .o_co1   (o_co1)
    );

    typedef struct {
        logic [N-1:0] p;
        logic [N-1:0] g;
        logic         ci;
        int           rmode;   // 0: rN all 0, 1: all 1, 2: random
        bit           masked;
        logic [N-1:0] exp_s;
        logic         exp_co;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rn(input int rmode);
        case (rmode)
            0:       trn = 1'b0;
            1:       trn = 1'b1;
            default: trn = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Issue one job from IDLE, wait for the result, optionally stall, then handshake.
    task automatic run_job(input logic [N-1:0] p0, input logic [N-1:0] p1,
                           input logic [N-1:0] g0, input logic [N-1:0] g1,
                           input logic ci0, input logic ci1,
                           input int rmode, input int stall, input bit busy,
                           output logic [N-1:0] s0, output logic [N-1:0] s1,
                           output logic co0, output logic co1);
        int cnt;
        tp0 = p0; tp1 = p1; tg0 = g0; tg1 = g1; tci0 = ci0; tci1 = ci1;
        tvalid = 1'b1;
        tready = 1'b0;
        set_rn(rmode);
        check("ready_before_accept", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        tvalid = busy;
        if (busy) begin
            tp0 = ~p0; tp1 = ~p1; tg0 = ~g0; tg1 = ~g1; tci0 = ~ci0; tci1 = ~ci1;
        end
        check("ready_low_busy", 32'(o_ready), 32'd0);
        cnt = 0;
        while (!o_valid && cnt < 200) begin
            set_rn(rmode);
            @(posedge clk); #1;
            cnt++;
        end
        check("latency_edges", 32'(cnt), 32'(2 * N));
        tvalid = 1'b0;
        s0 = o_s0; s1 = o_s1; co0 = o_co0; co1 = o_co1;
        for (int i = 0; i < stall; i++) begin
            trn = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("stall_hold", {12'd0, o_valid, o_ready, o_s0, o_s1, o_co0, o_co1},
                  {12'd0, 1'b1, 1'b0, s0, s1, co0, co1});
        end
        tready = 1'b1;
        @(posedge clk); #1;
        tready = 1'b0;
        check("hs_valid_drop", 32'(o_valid), 32'd0);
        check("hs_ready_back", 32'(o_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [7];
        logic [N-1:0] s0, s1, sa0, sa1;
        logic         co0, co1, ca0, ca1;
        logic [N-1:0] mp, mg;
        logic         mc;
        int           pulses;

        // a=0x5A b=0x3C -> 0x96
        vecs[0] = '{p: 8'h66, g: 8'h18, ci: 1'b0, rmode: 0, masked: 1'b0, exp_s: 8'h96, exp_co: 1'b0};
        vecs[1] = '{p: 8'hFE, g: 8'h01, ci: 1'b0, rmode: 2, masked: 1'b1, exp_s: 8'h00, exp_co: 1'b1};
        vecs[2] = '{p: 8'hFF, g: 8'h00, ci: 1'b1, rmode: 2, masked: 1'b1, exp_s: 8'h00, exp_co: 1'b1};
        vecs[3] = '{p: 8'h00, g: 8'hFF, ci: 1'b1, rmode: 1, masked: 1'b1, exp_s: 8'hFF, exp_co: 1'b1};
        vecs[4] = '{p: 8'hFF, g: 8'h00, ci: 1'b0, rmode: 2, masked: 1'b1, exp_s: 8'hFF, exp_co: 1'b0};
        // a=0xFF b=0xF0 -> 0x1EF
        vecs[5] = '{p: 8'h0F, g: 8'hF0, ci: 1'b0, rmode: 2, masked: 1'b1, exp_s: 8'hEF, exp_co: 1'b1};
        // a=0xFF b=0xAA ci=1 -> 0x1AA
        vecs[6] = '{p: 8'h55, g: 8'hAA, ci: 1'b1, rmode: 0, masked: 1'b1, exp_s: 8'hAA, exp_co: 1'b1};

        trst = 1'b1; tvalid = 1'b0; tready = 1'b0; trn = 1'b0;
        tp0 = '0; tp1 = '0; tg0 = '0; tg1 = '0; tci0 = 1'b0; tci1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {12'd0, o_valid, o_ready, o_s0, o_s1, o_co0, o_co1},
              {12'd0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0});
        trst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            mp = vecs[i].masked ? N'($urandom) : '0;
            mg = vecs[i].masked ? N'($urandom) : '0;
            mc = vecs[i].masked ? 1'($urandom_range(0, 1)) : 1'b0;
            run_job(vecs[i].p ^ mp, mp, vecs[i].g ^ mg, mg, vecs[i].ci ^ mc, mc,
                    vecs[i].rmode, 0, 1'b0, s0, s1, co0, co1);
            check($sformatf("vec%0d_sum", i), 32'(s0 ^ s1), 32'(vecs[i].exp_s));
            check($sformatf("vec%0d_cout", i), 32'(co0 ^ co1), 32'(vecs[i].exp_co));
        end

        // Same masked job with rN all 0 then all 1: same value, shares differ
        // in every bit whose carry came through the gadget.
        mp = 8'hA5; mg = 8'h3C; mc = 1'b1;
        run_job(8'hFE ^ mp, mp, 8'h01 ^ mg, mg, 1'b0 ^ mc, mc, 0, 0, 1'b0, sa0, sa1, ca0, ca1);
        run_job(8'hFE ^ mp, mp, 8'h01 ^ mg, mg, 1'b0 ^ mc, mc, 1, 0, 1'b0, s0, s1, co0, co1);
        check("r0_sum", 32'(sa0 ^ sa1), 32'h00);
        check("r1_sum", 32'(s0 ^ s1), 32'h00);
        check("r0_cout", 32'(ca0 ^ ca1), 32'd1);
        check("r1_cout", 32'(co0 ^ co1), 32'd1);
        check("rflip_s0_diff", 32'(sa0 ^ s0), 32'hFE);
        check("rflip_co0_diff", 32'(ca0 ^ co0), 32'd1);

        // Five-cycle stall in DONE.
        run_job(8'h66, 8'h00, 8'h18, 8'h00, 1'b0, 1'b0, 2, 5, 1'b0, s0, s1, co0, co1);
        check("stall_sum", 32'(s0 ^ s1), 32'h96);
        check("stall_cout", 32'(co0 ^ co1), 32'd0);

        // Reset in cycle T+7 of a running job.
        tp0 = 8'h66; tp1 = 8'h00; tg0 = 8'h18; tg1 = 8'h00; tci0 = 1'b1; tci1 = 1'b0;
        tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0;
        repeat (6) begin
            trn = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        trst = 1'b1;
        @(posedge clk); #1;
        trst = 1'b0;
        check("midjob_reset", {12'd0, o_valid, o_ready, o_s0, o_s1, o_co0, o_co1},
              {12'd0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0});
        run_job(8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2, 0, 1'b0, s0, s1, co0, co1);
        check("post_reset_sum", 32'(s0 ^ s1), 32'h00);
        check("post_reset_cout", 32'(co0 ^ co1), 32'd1);

        // i_valid held high with garbage operands while busy.
        run_job(8'h5A, 8'h3C, 8'h08, 8'h10, 1'b1, 1'b1, 2, 0, 1'b1, s0, s1, co0, co1);
        check("busy_sum", 32'(s0 ^ s1), 32'h96);
        check("busy_cout", 32'(co0 ^ co1), 32'd0);
        pulses = 0;
        for (int i = 0; i < 2 * N + 4; i++) begin
            @(posedge clk); #1;
            if (o_valid) pulses++;
        end
        check("no_extra_valid", 32'(pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/masked_carry_serial.md
Name: masked_carry_serial

Overview:
- Downstream consumer of the masked PG stage: takes first-order Boolean-shared propagate/generate vectors (two shares each) plus a shared carry-in.
- Resolves the carry chain bit-serially, c[k+1] = g[k] ^ (p[k] & c[k]), and produces shared sum s[k] = p[k] ^ c[k] and shared carry-out.
- The only non-linear step is p&c. It uses a registered domain-oriented (DOM) AND gadget with one fresh random bit per sum bit, so no combinational path mixes share domains.

Parameters:
- N, 8, operand width in bits (N >= 1).
- CW, $clog2(N) (minimum 1), width of the bit counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input job valid.
- o_ready  output  1  block can accept a job (high only in IDLE).
- i_p0  input  N  propagate share 0.
- i_p1  input  N  propagate share 1.
- i_g0  input  N  generate share 0.
- i_g1  input  N  generate share 1.
- i_ci0  input  1  carry-in share 0.
- i_ci1  input  1  carry-in share 1.
- i_rN  input  1  fresh random bit; sampled only in phase A of each bit.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_s0  output  N  sum share 0.
- o_s1  output  N  sum share 1.
- o_co0  output  1  carry-out share 0.
- o_co1  output  1  carry-out share 1.

Behaviour:
- The reset is synchronous and active-high, and the block has one clock.
- On i_rst, the next edge sets:
  - state to IDLE, counter to 0;
  - o_valid = 0, o_ready = 1;
  - o_s0, o_s1, o_co0 and o_co1 to 0;
  - all internal share registers to 0.
- Reset overrides everything; an in-flight job is discarded.
- FSM states are IDLE, RUN_A, RUN_B and DONE.
- IDLE:
  - o_ready = 1.
  - On i_valid & o_ready (cycle T), latch p/g shares and load carry registers c0 = i_ci0, c1 = i_ci1.
  - Set k = 0 and go to RUN_A.
- RUN_A for bit k:
  - s0[k] <= p0[k] ^ c0 and s1[k] <= p1[k] ^ c1.
  - Register DOM cross terms x0 <= (p0[k] & c1) ^ i_rN and x1 <= (p1[k] & c0) ^ i_rN.
  - Register inner terms n0 <= g0[k] ^ (p0[k] & c0) and n1 <= g1[k] ^ (p1[k] & c1).
  - Go to RUN_B.
- RUN_B:
  - c0 <= n0 ^ x0 and c1 <= n1 ^ x1.
  - If k == N-1, go to DONE; otherwise k <= k+1 and go to RUN_A.
- DONE:
  - o_valid = 1; o_co0/o_co1 = c0/c1; o_s0/o_s1 = completed sum registers.
  - Outputs are held stable while i_ready = 0.
  - On i_ready, go to IDLE (o_valid drops next cycle).
  - No accept occurs in the same cycle as a DONE handshake.
- Latency:
  - Accept at T; bit k phase A at T+1+2k, phase B at T+2+2k.
  - o_valid first high in cycle T+2N+1; throughput is one job per 2N+2 cycles minimum.
- Inputs i_p*, i_g* and i_ci* are ignored outside the accept cycle.
- i_rN is ignored outside RUN_A.
- Share-domain rule:
  - No combinational path combines share-0 and share-1 signals except through x0/x1, which are registered before recombination.
  - Share-0 and share-1 registers are never XORed together inside the block.
- Correctness:
  - (o_s0 ^ o_s1) equals the unmasked sum of the unmasked p/g chain.
  - (o_co0 ^ o_co1) equals the unmasked carry-out.
  - Both hold for any input masks and any i_rN sequence.
- N = 1 works: one RUN_A/RUN_B pair, then DONE.

Decomposition:
- Package masked_pkg holds:
  - state enum (IDLE, RUN_A, RUN_B, DONE);
  - default N;
  - the share-pair struct (bit s0, s1) used by PG and carry stages.
- Sub-module masked_dom_and:
  - one-bit DOM AND with registered cross terms;
  - inputs are the a/b shares, r and the capture enable;
  - outputs are the registered inner and cross terms;
  - the top level owns only the final XOR and the FSM.

Test Plan:
- Unmasked a=0x5A, b=0x3C (p=0x66, g=0x18), ci=0, masks zero, i_rN=0 -> at T+17: s0^s1=0x96, co0^co1=0, o_valid=1.
- p=0xFE, g=0x01, ci=0, random masks on every share, random i_rN -> s0^s1=0x00, co0^co1=1.
- Same job as previous with i_rN all-0 versus all-1 -> identical unmasked results; individual output shares differ.
- i_ready held 0 for 5 cycles after o_valid -> outputs stable, o_ready=0; on i_ready=1, IDLE next cycle with o_ready=1.
- i_rst asserted at T+7 mid-job -> next cycle all outputs 0, o_ready=1; a new job (p=0xFF, g=0x00, ci share pair (1,0)) -> s0^s1=0x00, co=1.
- i_valid high while busy -> ignored; the first job's result is unchanged and only one o_valid pulse per accepted job.
